// File: rtl/rtsnoc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtsnoc_pkg                                                           |
// | Shared RTSNoC header geometry, port encodings, CMD/STAT bits, states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rtsnoc_pkg;

    localparam int NOC_PORT_W  = 38;
    localparam int NOC_LOCAL_W = 3;
    localparam int NOC_DATA_W  = 16;

    // Field widths for the default 2x2 geometry; other geometries use the functions.
    localparam int SOC_XY_SIZE     = 2;
    localparam int NOC_HEADER_SIZE = 2 * (SOC_XY_SIZE + NOC_LOCAL_W);
    localparam int NOC_BUS_SIZE    = NOC_HEADER_SIZE + NOC_DATA_W;

    function automatic int noc_orig_size(input int sx, input int sy);
        return sx + sy + NOC_LOCAL_W;
    endfunction

    function automatic int noc_bus_size(input int sx, input int sy, input int dw);
        return 2 * noc_orig_size(sx, sy) + dw;
    endfunction

    localparam logic [2:0] NN = 3'd0;
    localparam logic [2:0] NE = 3'd1;
    localparam logic [2:0] EE = 3'd2;
    localparam logic [2:0] SE = 3'd3;
    localparam logic [2:0] SS = 3'd4;
    localparam logic [2:0] SW = 3'd5;
    localparam logic [2:0] WW = 3'd6;
    localparam logic [2:0] NW = 3'd7;

    localparam int CMD_WE_BIT   = 15;
    localparam int CMD_SEL_MSB  = 14;
    localparam int CMD_SEL_LSB  = 11;
    localparam int CMD_TAG_MSB  = 7;
    localparam int STAT_WE_BIT  = 15;
    localparam int STAT_ERR_BIT = 14;

    typedef enum logic [3:0] {
        RX_CMD    = 4'd0,
        RX_ADR_HI = 4'd1,
        RX_ADR_LO = 4'd2,
        RX_DAT_HI = 4'd3,
        RX_DAT_LO = 4'd4,
        WB_REQ    = 4'd5,
        TX_STAT   = 4'd6,
        TX_DAT_HI = 4'd7,
        TX_DAT_LO = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rtsnoc_wishbone_master_flit_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtsnoc_flit_port                                                     |
// | Router-side rd/wr pulse generation, gap timing, header pack/unpack   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rtsnoc_flit_port
    import rtsnoc_pkg::*;
#(
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16
) (
    input  logic                                              clk_i,
    input  logic                                              rst_n_i,
    input  logic                                              i_rx_en,
    output logic                                              o_rx_fire,
    output logic [NOC_DATA_WIDTH-1:0]                         o_rx_data,
    output logic [noc_orig_size(SOC_SIZE_X, SOC_SIZE_Y)-1:0] o_rx_orig,
    input  logic                                              i_tx_en,
    input  logic [NOC_DATA_WIDTH-1:0]                         i_tx_data,
    input  logic [noc_orig_size(SOC_SIZE_X, SOC_SIZE_Y)-1:0] i_tx_src,
    input  logic [noc_orig_size(SOC_SIZE_X, SOC_SIZE_Y)-1:0] i_tx_dst,
    output logic                                              o_tx_fire,
    output logic [NOC_PORT_W-1:0]                             o_noc_din,
    output logic                                              o_noc_wr,
    output logic                                              o_noc_rd,
    input  logic [NOC_PORT_W-1:0]                             i_noc_dout,
    input  logic                                              i_noc_wait,
    input  logic                                              i_noc_nd
);

    localparam int c_ORIG_W = noc_orig_size(SOC_SIZE_X, SOC_SIZE_Y);
    localparam int c_BUS_W  = noc_bus_size(SOC_SIZE_X, SOC_SIZE_Y, NOC_DATA_WIDTH);

    logic                  r_rd;
    logic                  r_tx_gap;
    logic [NOC_PORT_W-1:0] r_din;
    logic [NOC_PORT_W-1:0] w_packed;
    logic                  w_unused_rx;

    // r_rd doubles as the RX gap: the router still shows the popped flit then.
    assign o_rx_fire   = i_rx_en & i_noc_nd & ~r_rd;
    assign o_noc_rd    = r_rd;
    assign o_rx_data   = i_noc_dout[NOC_DATA_WIDTH-1:0];
    assign o_rx_orig   = i_noc_dout[c_BUS_W-1 -: c_ORIG_W];
    assign w_unused_rx = ^i_noc_dout;

    always_comb begin
        w_packed              = '0;
        w_packed[c_BUS_W-1:0] = {i_tx_src, i_tx_dst, i_tx_data};
    end

    assign o_noc_wr  = i_tx_en & ~i_noc_wait & ~r_tx_gap;
    assign o_tx_fire = o_noc_wr;
    assign o_noc_din = o_noc_wr ? w_packed : r_din;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_rd     <= 1'b0;
            r_tx_gap <= 1'b0;
            r_din    <= '0;
        end else begin
            r_rd     <= o_rx_fire;
            r_tx_gap <= o_noc_wr;
            if (o_noc_wr) begin
                r_din <= w_packed;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtsnoc_wishbone_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtsnoc_wishbone_master                                               |
// | NoC request flits -> single-beat Wishbone cycles -> response flits   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rtsnoc_wishbone_master
    import rtsnoc_pkg::*;
#(
    parameter int NOC_LOCAL_ADR  = 0,
    parameter int NOC_X          = 0,
    parameter int NOC_Y          = 0,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    parameter int NOC_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic [NOC_PORT_W-1:0] noc_din_o,
    output logic                  noc_wr_o,
    output logic                  noc_rd_o,
    input  logic [NOC_PORT_W-1:0] noc_dout_i,
    input  logic                  noc_wait_i,
    input  logic                  noc_nd_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic [7:0]            err_cnt_o
);

    localparam int c_ORIG_W = noc_orig_size(SOC_SIZE_X, SOC_SIZE_Y);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_ORIG_W-1:0] c_SELF = {NOC_X[SOC_SIZE_X-1:0], NOC_Y[SOC_SIZE_Y-1:0],
                                              NOC_LOCAL_ADR[NOC_LOCAL_W-1:0]};

    state_t                      r_state;
    state_t                      w_next;
    logic [c_ORIG_W-1:0]         r_orig;
    logic                        r_we;
    logic [3:0]                  r_sel;
    logic [7:0]                  r_tag;
    logic [31:0]                 r_adr;
    logic [31:0]                 r_wdat;
    logic [31:0]                 r_rdat;
    logic                        r_err;
    logic [c_TMO_W-1:0]          r_tmo_cnt;
    logic [7:0]                  r_err_cnt;

    logic                        w_rx_en;
    logic                        w_rx_fire;
    logic [NOC_DATA_WIDTH-1:0]   w_rx_data;
    logic [c_ORIG_W-1:0]         w_rx_orig;
    logic                        w_tx_en;
    logic                        w_tx_fire;
    logic [NOC_DATA_WIDTH-1:0]   w_tx_data;
    logic [NOC_DATA_WIDTH-1:0]   w_stat;
    logic                        w_wb_act;
    logic                        w_orig_bad;
    logic                        w_take_cmd;
    logic                        w_tmo;
    logic                        w_wb_done;
    logic                        w_wb_fail;
    logic                        w_err_inc;

    rtsnoc_flit_port #(
        .SOC_SIZE_X     (SOC_SIZE_X),
        .SOC_SIZE_Y     (SOC_SIZE_Y),
        .NOC_DATA_WIDTH (NOC_DATA_WIDTH)
    ) u_port (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_rx_en    (w_rx_en),
        .o_rx_fire  (w_rx_fire),
        .o_rx_data  (w_rx_data),
        .o_rx_orig  (w_rx_orig),
        .i_tx_en    (w_tx_en),
        .i_tx_data  (w_tx_data),
        .i_tx_src   (c_SELF),
        .i_tx_dst   (r_orig),
        .o_tx_fire  (w_tx_fire),
        .o_noc_din  (noc_din_o),
        .o_noc_wr   (noc_wr_o),
        .o_noc_rd   (noc_rd_o),
        .i_noc_dout (noc_dout_i),
        .i_noc_wait (noc_wait_i),
        .i_noc_nd   (noc_nd_i)
    );

    // A flit from a foreign origin mid-packet restarts decoding as a fresh CMD.
    assign w_orig_bad = (r_state != RX_CMD) && (w_rx_orig != r_orig);
    assign w_take_cmd = (r_state == RX_CMD) || w_orig_bad;
    assign w_tmo      = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_wb_done  = wb_ack_i | wb_err_i | w_tmo;
    assign w_wb_fail  = wb_err_i | (w_tmo & ~wb_ack_i);
    assign w_err_inc  = (w_rx_fire && w_orig_bad) || (w_wb_act && w_wb_done && w_wb_fail);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= RX_CMD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_CMD:    if (w_rx_fire) w_next = RX_ADR_HI;
            RX_ADR_HI: if (w_rx_fire) w_next = w_orig_bad ? RX_ADR_HI : RX_ADR_LO;
            RX_ADR_LO: if (w_rx_fire) w_next = w_orig_bad ? RX_ADR_HI : (r_we ? RX_DAT_HI : WB_REQ);
            RX_DAT_HI: if (w_rx_fire) w_next = w_orig_bad ? RX_ADR_HI : RX_DAT_LO;
            RX_DAT_LO: if (w_rx_fire) w_next = w_orig_bad ? RX_ADR_HI : WB_REQ;
            WB_REQ:    if (w_wb_done) w_next = TX_STAT;
            TX_STAT:   if (w_tx_fire) w_next = r_we ? RX_CMD : TX_DAT_HI;
            TX_DAT_HI: if (w_tx_fire) w_next = TX_DAT_LO;
            TX_DAT_LO: if (w_tx_fire) w_next = RX_CMD;
            default:   w_next = RX_CMD;
        endcase
    end

    always_comb begin
        w_stat               = '0;
        w_stat[STAT_WE_BIT]  = r_we;
        w_stat[STAT_ERR_BIT] = r_err;
        w_stat[CMD_TAG_MSB:0] = r_tag;
    end

    always_comb begin
        w_rx_en   = 1'b0;
        w_tx_en   = 1'b0;
        w_wb_act  = 1'b0;
        w_tx_data = '0;
        case (r_state)
            RX_CMD, RX_ADR_HI, RX_ADR_LO, RX_DAT_HI, RX_DAT_LO: w_rx_en = 1'b1;
            WB_REQ:    w_wb_act = 1'b1;
            TX_STAT:   begin w_tx_en = 1'b1; w_tx_data = w_stat;        end
            TX_DAT_HI: begin w_tx_en = 1'b1; w_tx_data = r_rdat[31:16]; end
            TX_DAT_LO: begin w_tx_en = 1'b1; w_tx_data = r_rdat[15:0];  end
            default:   w_rx_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_orig    <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_tag     <= '0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_rdat    <= '0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_rx_fire) begin
                if (w_take_cmd) begin
                    r_orig <= w_rx_orig;
                    r_we   <= w_rx_data[CMD_WE_BIT];
                    r_sel  <= w_rx_data[CMD_SEL_MSB:CMD_SEL_LSB];
                    r_tag  <= w_rx_data[CMD_TAG_MSB:0];
                end else begin
                    case (r_state)
                        RX_ADR_HI: r_adr[31:16]  <= w_rx_data;
                        RX_ADR_LO: r_adr[15:0]   <= w_rx_data;
                        RX_DAT_HI: r_wdat[31:16] <= w_rx_data;
                        RX_DAT_LO: r_wdat[15:0]  <= w_rx_data;
                        default:   r_adr         <= r_adr;
                    endcase
                end
            end
            if (w_wb_act && !w_wb_done) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_wb_act && w_wb_done) begin
                r_err <= w_wb_fail;
                if (!r_we) begin
                    r_rdat <= w_wb_fail ? 32'h0 : wb_dat_i;
                end
            end
            if (w_err_inc && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign wb_cyc_o  = w_wb_act;
    assign wb_stb_o  = w_wb_act;
    assign wb_we_o   = w_wb_act & r_we;
    assign wb_adr_o  = w_wb_act ? r_adr  : 32'h0;
    assign wb_sel_o  = w_wb_act ? r_sel  : 4'h0;
    assign wb_dat_o  = w_wb_act ? r_wdat : 32'h0;
    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rtsnoc_wishbone_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rtsnoc_wishbone_master                                            |
// | Scoreboard bench: router + Wishbone slave models, queued expectations|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rtsnoc_wishbone_master;
    import rtsnoc_pkg::*;

    localparam logic [4:0] ME  = {1'b0, 1'b1, WW};
    localparam logic [4:0] SRC_A = {1'b1, 1'b0, EE};
    localparam logic [4:0] SRC_B = {1'b0, 1'b0, NN};
    localparam logic [4:0] SRC_S = {1'b1, 1'b1, SS};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [37:0] noc_din_o;
    logic        noc_wr_o, noc_rd_o;
    logic [37:0] noc_dout_i = '0;
    logic        noc_wait_i = 1'b0;
    logic        noc_nd_i = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [7:0]  err_cnt_o;

    always #5 clk = ~clk;

    rtsnoc_wishbone_master #(
        .NOC_LOCAL_ADR (6), .NOC_X (0), .NOC_Y (1),
        .SOC_SIZE_X (1), .SOC_SIZE_Y (1), .NOC_DATA_WIDTH (16), .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i (clk), .rst_n_i (rst_n),
        .noc_din_o (noc_din_o), .noc_wr_o (noc_wr_o), .noc_rd_o (noc_rd_o),
        .noc_dout_i (noc_dout_i), .noc_wait_i (noc_wait_i), .noc_nd_i (noc_nd_i),
        .wb_cyc_o (wb_cyc_o), .wb_stb_o (wb_stb_o), .wb_we_o (wb_we_o),
        .wb_adr_o (wb_adr_o), .wb_sel_o (wb_sel_o), .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i), .wb_ack_i (wb_ack_i), .wb_err_i (wb_err_i),
        .err_cnt_o (err_cnt_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          len;
    } wb_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_tx = 0;
    logic [37:0] rxq[$];
    logic [37:0] txq[$];
    wb_t         wbq[$];

    int          s_mode = 0;   // 0 ack, 1 err, 2 never respond
    int          s_delay = 1;
    int          s_cnt = 0;
    int          stb_len = 0;
    int          cur_len = 0;
    logic        prev_stb = 1'b0;

    function automatic logic [37:0] mk(input logic [4:0] src, input logic [4:0] dst,
                                       input logic [15:0] d);
        return {12'h000, src, dst, d};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    // Router RX pop: the flit leaves the router at the edge that sees rd_o.
    always @(posedge clk) begin
        if (noc_rd_o && rxq.size() > 0) void'(rxq.pop_front());
    end

    always @(negedge clk) begin
        if (noc_wr_o) begin
            n_tx++;
            if (txq.size() == 0) fail_now("tx_unexpected");
            else chk("tx_flit", noc_din_o, txq.pop_front());
        end
        if (wb_stb_o && !prev_stb) begin
            if (wbq.size() == 0) begin
                fail_now("wb_unexpected");
                cur_len = 0;
            end else begin
                wb_t e;
                e = wbq.pop_front();
                chk("wb_we_adr_sel", {wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o}, {1'b1, e.we, e.adr, e.sel});
                if (e.we) chk("wb_wdata", wb_dat_o, e.dat);
                chk("wb_latency_rd", noc_rd_o, 1'b1);
                cur_len = e.len;
            end
        end
        if (wb_stb_o) stb_len++;
        if (!wb_stb_o && prev_stb) begin
            if (cur_len != 0) chk("wb_len", stb_len, cur_len);
            stb_len = 0;
        end
        prev_stb = wb_stb_o;
        if (wb_stb_o) begin
            s_cnt++;
            wb_ack_i = (s_mode == 0) && (s_cnt == s_delay);
            wb_err_i = (s_mode == 1) && (s_cnt == s_delay);
        end else begin
            s_cnt = 0;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
        noc_nd_i   = (rxq.size() > 0);
        noc_dout_i = (rxq.size() > 0) ? rxq[0] : '0;
    end

    task automatic req(input logic [4:0] src, input logic [15:0] cmd, input logic [31:0] adr,
                       input logic [31:0] dat);
        rxq.push_back(mk(src, ME, cmd));
        rxq.push_back(mk(src, ME, adr[31:16]));
        rxq.push_back(mk(src, ME, adr[15:0]));
        if (cmd[15]) begin
            rxq.push_back(mk(src, ME, dat[31:16]));
            rxq.push_back(mk(src, ME, dat[15:0]));
        end
    endtask

    task automatic exp_wb(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int len);
        wb_t e;
        e.we = we; e.adr = adr; e.sel = sel; e.dat = dat; e.len = len;
        wbq.push_back(e);
    endtask

    task automatic exp_tx(input logic [4:0] dst, input logic [15:0] stat, input logic [31:0] rd,
                          input logic has_data);
        txq.push_back(mk(ME, dst, stat));
        if (has_data) begin
            txq.push_back(mk(ME, dst, rd[31:16]));
            txq.push_back(mk(ME, dst, rd[15:0]));
        end
    endtask

    task automatic wait_idle(input string nm);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(posedge clk);
            if (rxq.size() == 0 && txq.size() == 0 && !wb_cyc_o) done = 1'b1;
        end
        if (!done) fail_now({nm, "_timeout"});
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {noc_din_o, noc_wr_o, noc_rd_o, wb_cyc_o, wb_stb_o, wb_we_o,
                              wb_sel_o, wb_adr_o[15:0]}, '0);
        chk("reset_busses", {wb_adr_o, wb_dat_o, err_cnt_o}, '0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Write, ack in second stb cycle
        s_mode = 0; s_delay = 2;
        exp_wb(1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 2);
        exp_tx(SRC_A, 16'h80A5, 32'h0, 1'b0);
        req(SRC_A, 16'hF8A5, 32'h0000_1000, 32'hDEAD_BEEF);
        wait_idle("write");
        chk("err_cnt_write", err_cnt_o, 8'd0);

        // Read
        s_mode = 0; s_delay = 1; wb_dat_i = 32'h1234_5678;
        exp_wb(1'b0, 32'h0000_0040, 4'hF, 32'h0, 1);
        exp_tx(SRC_A, 16'h0003, 32'h1234_5678, 1'b1);
        req(SRC_A, 16'h7803, 32'h0000_0040, 32'h0);
        wait_idle("read");

        // Error-terminated read: data flits forced to zero
        s_mode = 1; s_delay = 1; wb_dat_i = 32'hCAFE_F00D;
        exp_wb(1'b0, 32'h0000_0010, 4'h3, 32'h0, 1);
        exp_tx(SRC_B, 16'h4007, 32'h0, 1'b1);
        req(SRC_B, 16'h1807, 32'h0000_0010, 32'h0);
        wait_idle("err_read");
        chk("err_cnt_err", err_cnt_o, 8'd1);

        // Timeout on a write, no slave response
        s_mode = 2;
        exp_wb(1'b1, 32'h0000_0200, 4'h1, 32'h0000_00AB, 8);
        exp_tx(SRC_A, 16'hC011, 32'h0, 1'b0);
        req(SRC_A, 16'h8811, 32'h0000_0200, 32'h0000_00AB);
        wait_idle("timeout");
        chk("err_cnt_tmo", err_cnt_o, 8'd2);

        // Origin switch: SS flit in ADR_HI slot becomes the new CMD
        s_mode = 0; s_delay = 1; wb_dat_i = 32'hA5A5_5A5A;
        exp_wb(1'b0, 32'h0000_0080, 4'hF, 32'h0, 1);
        exp_tx(SRC_S, 16'h0022, 32'hA5A5_5A5A, 1'b1);
        rxq.push_back(mk(SRC_B, ME, 16'h7821));
        req(SRC_S, 16'h7822, 32'h0000_0080, 32'h0);
        wait_idle("origin");
        chk("err_cnt_abort", err_cnt_o, 8'd3);

        // Backpressure during TX_DAT_HI
        begin
            int  base;
            logic seen;
            s_mode = 0; s_delay = 1; wb_dat_i = 32'h0BAD_CAFE;
            exp_wb(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1);
            exp_tx(SRC_A, 16'h0044, 32'h0BAD_CAFE, 1'b1);
            base = n_tx;
            seen = 1'b0;
            req(SRC_A, 16'h7844, 32'h0000_0100, 32'h0);
            for (int k = 0; k < 500 && !seen; k++) begin
                @(posedge clk);
                if (n_tx == base + 1) seen = 1'b1;
            end
            if (!seen) fail_now("bp_stat_timeout");
            #1 noc_wait_i = 1'b1;
            base = n_tx;
            repeat (20) @(posedge clk);
            chk("bp_no_wr", n_tx, base);
            #1 noc_wait_i = 1'b0;
            wait_idle("backpressure");
            chk("err_cnt_bp", err_cnt_o, 8'd3);
        end

        // Reset while a Wishbone cycle is open
        begin
            logic seen;
            seen = 1'b0;
            s_mode = 2;
            exp_wb(1'b1, 32'h0000_0300, 4'hF, 32'h1111_2222, 0);
            req(SRC_A, 16'hF855, 32'h0000_0300, 32'h1111_2222);
            for (int k = 0; k < 500 && !seen; k++) begin
                @(negedge clk);
                if (wb_stb_o) seen = 1'b1;
            end
            if (!seen) fail_now("rst_stb_timeout");
            @(posedge clk); #1 rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("midrst_outputs", {noc_din_o, noc_wr_o, noc_rd_o, wb_cyc_o, wb_stb_o, wb_we_o,
                                   wb_sel_o, err_cnt_o}, '0);
            chk("midrst_busses", {wb_adr_o, wb_dat_o}, '0);
            @(posedge clk); #1 rst_n = 1'b1;
        end

        s_mode = 0; s_delay = 1; wb_dat_i = 32'h600D_F00D;
        exp_wb(1'b0, 32'h0000_0044, 4'hF, 32'h0, 1);
        exp_tx(SRC_A, 16'h00AA, 32'h600D_F00D, 1'b1);
        req(SRC_A, 16'h78AA, 32'h0000_0044, 32'h0);
        wait_idle("post_reset");
        chk("err_cnt_post_reset", err_cnt_o, 8'd0);
        chk("txq_drained", txq.size(), 0);
        chk("wbq_drained", wbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rtsnoc_wishbone_master.md
Name: rtsnoc_wishbone_master

Overview:
NoC-to-Wishbone bridge and the initiator-side counterpart of the RTSNoC Wishbone slave port. It attaches to one RTSNoC router port, assembles 16-bit request flits into single-beat Wishbone read/write cycles on a local bus, and returns response flits to the originating node. It lets a remote CPU reach memory-mapped peripherals on this node through the NoC.

Parameters:
NOC_LOCAL_ADR, 0, router local port of this node (3 bits, NN..NW encoding)
NOC_X, 0, X address of this router
NOC_Y, 0, Y address of this router
SOC_SIZE_X, 1, log2 X dimension
SOC_SIZE_Y, 1, log2 Y dimension
NOC_DATA_WIDTH, 16, flit payload width; fixed at 16 for this block
TIMEOUT_CYCLES, 255, Wishbone cycles to wait for ack/err before a timeout error

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
noc_din_o  out  38  TX flit: {X_orig,Y_orig,local_orig,X_dst,Y_dst,local_dst,data}; bits above NOC_BUS_SIZE are 0
noc_wr_o  out  1  one-cycle TX strobe
noc_rd_o  out  1  one-cycle RX acknowledge
noc_dout_i  in  38  RX flit, same packing
noc_wait_i  in  1  router cannot accept a TX flit
noc_nd_i  in  1  RX flit valid
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  write enable
wb_adr_o  out  32  byte address
wb_sel_o  out  4  byte selects
wb_dat_o  out  32  write data
wb_dat_i  in  32  read data
wb_ack_i  in  1  normal termination
wb_err_i  in  1  error termination
err_cnt_o  out  8  saturating count of errors, aborts and timeouts

Behaviour:
- Reset (rst_n_i=0 at clk_i edge): all outputs 0, FSM in RX_CMD, counters 0. This applies mid-operation: an open Wishbone cycle is dropped immediately and a partial packet is discarded.
- Request packet, flit order: CMD, ADR_HI, ADR_LO, then DAT_HI and DAT_LO for writes only.
  - CMD data: [15]=we, [14:11]=sel, [10:8]=0, [7:0]=tag.
  - HI flits carry bits 31:16; LO flits carry bits 15:0.
- RX handshake:
  - In an RX state with noc_nd_i=1, capture noc_dout_i and pulse noc_rd_o for one cycle.
  - The next cycle is a gap in which noc_nd_i is ignored.
  - Exactly one flit is consumed per rd_o pulse.
- The origin {X,Y,local} of the CMD flit is latched. A later flit of the same packet with a different origin:
  - aborts the request and increments err_cnt_o;
  - is then re-interpreted as a new CMD flit.
- WB_REQ state:
  - Drive cyc/stb/we/adr/sel/dat; hold them stable until termination.
  - Termination is wb_ack_i, wb_err_i, or the timeout counter reaching TIMEOUT_CYCLES.
  - Deassert cyc/stb in the cycle after termination.
  - Capture wb_dat_i on ack for reads.
  - If ack and err are asserted together, err wins.
- Response packet:
  - Destination = latched origin. Origin = {NOC_X, NOC_Y, NOC_LOCAL_ADR}.
  - STAT flit: [15]=we, [14]=err (wb_err or timeout), [13:8]=0, [7:0]=tag.
  - Reads append DAT_HI and DAT_LO. On an error read, the data flits are sent with value 0.
- TX handshake:
  - Pulse noc_wr_o for one cycle only when noc_wait_i=0; noc_din_o is valid in that cycle and held until the next flit.
  - After a pulse, one gap cycle follows; then wait for noc_wait_i=0 again.
- States: RX_CMD → RX_ADR_HI → RX_ADR_LO → (we ? RX_DAT_HI → RX_DAT_LO) → WB_REQ → TX_STAT → (!we ? TX_DAT_HI → TX_DAT_LO) → RX_CMD.
- No new request is accepted while a response is pending; the router buffers incoming flits.
- err_cnt_o increments by 1 per error, abort or timeout and saturates at 255.
- Latency: first WB cycle with stb=1 is the cycle after the last request flit is consumed.

Decomposition:
- Package rtsnoc_pkg holds:
  - the header field widths: SOC_XY_SIZE, NOC_HEADER_SIZE, NOC_BUS_SIZE;
  - the local-port encodings NN..NW;
  - the CMD/STAT bit-position constants;
  - the FSM state enumeration.
- One sub-module is natural: rtsnoc_flit_port, which wraps the rd_o/wr_o pulse, the gap timing and the header pack/unpack.

Test Plan:
- Write: from (X1,Y0,EE), send CMD=0xF8A5, adr 0x0000_1000, data 0xDEAD_BEEF, ack after 2 cycles → one WB write with sel=0xF; STAT=0x80A5 routed to (X1,Y0,EE) with origin = node params.
- Read: CMD=0x7803, adr 0x0000_0040, wb_dat_i=0x1234_5678 → flits STAT 0x0003, 0x1234, 0x5678 in order.
- Error and timeout:
  - wb_err_i on a read → STAT bit14=1, data flits 0, err_cnt_o=1.
  - With TIMEOUT_CYCLES=8 and no ack → cyc drops after 8 cycles, STAT bit14=1.
- Origin switch: CMD from NN, then ADR_HI from SS → abort, err_cnt_o increments, the SS flit is treated as CMD.
- Backpressure: hold noc_wait_i=1 for 20 cycles during TX_DAT_HI → no wr_o pulse; on release, DAT_HI then DAT_LO sent unchanged.
- Reset mid-WB_REQ with stb=1 → the next cycle has all outputs 0, and the next valid CMD is processed normally.
